id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX.
- Supplies ex_rs1/ex_rs2 to the forwarding unit and the ALU operand muxes.
- Inserts bubbles for load-use stalls and for branch/jump flushes, and keeps saturating stall/flush event counters.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediate.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  register-file reads and immediate
- id_alu_ctrl  in  4  ALU operation
- id_funct3  in  3  memory size / branch type
- id_ctrl  in  7  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump}
- ex_flush  in  1  EX resolved a taken branch or jump
- hold  in  1  downstream freeze (multi-cycle unit); register holds its contents
- stall  out  1  combinational; freezes PC and IF/ID
- ex_valid  out  1  registered valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered; ex_rs1/ex_rs2 feed forwarding
- ex_alu_ctrl  out  4  registered
- ex_funct3  out  3  registered
- ex_ctrl  out  7  registered, same bit order as id_ctrl
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (async, rst=1): every registered output goes to 0. ex_valid=0 and ex_ctrl=0, so the reset state is a bubble. Counters go to 0.
- Load-use detection (lu):
  - lu = ex_valid & ex_ctrl.MemRead & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall = lu & ~ex_flush & ~hold.
  - On a flush, the ID instruction is wrong-path, so no stall is raised.
  - During hold, upstream is frozen by the same hold signal.
- Per-edge update priority:
  1. ex_flush=1: load bubble. flush_cnt++ if ex_valid was 1. Flush wins over hold and lu.
  2. hold=1: all registers keep their value. Counters unchanged.
  3. lu=1: load bubble. stall_cnt++.
  4. Otherwise: capture all id_* fields. ex_valid <= id_valid.
- Bubble definition:
  - ex_valid=0, ex_ctrl=0, ex_rd=ex_rs1=ex_rs2=0, so the forwarding unit sees no match.
  - Data fields are cleared to 0 (deterministic, eases checking).
- If id_valid=0, control is still captured as given; the decoder guarantees id_ctrl=0 in that case.
- Latency: 1 cycle ID to EX. A load-use stall lasts exactly 1 cycle: the load moves to MEM on the next edge, which clears lu.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Package riscv_pkg:
  - ALU op encodings (4 bits)
  - control-bundle bit positions CTRL_REGWRITE..CTRL_JUMP and CTRL_W=7
  - REG_X0=5'd0
- One sub-module, load_use_detect: combinational lu equation. The top level is registers plus counters.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst asserted while ex_valid=1, ex_ctrl=7'h7F.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
- Load-use:
  - Stimulus: lw x5 in EX (MemRead=1, rd=5); ID is add x6,x5,x7 with uses_rs1=1.
  - Response: stall=1 that cycle. Next edge loads a bubble (ex_valid=0, ex_rd=0) and stall_cnt=1. The following edge captures the add and stall=0.
- No false stall:
  - Stimulus 1: lw x0 in EX, ID reads x0. Response: stall=0.
  - Stimulus 2: lw x5 in EX, ID is lui with uses_rs1=uses_rs2=0 and rs1 field=5. Response: stall=0.
- Flush beats stall and hold:
  - Stimulus: ex_flush=1, lu=1 and hold=1 together.
  - Response: stall=0. Next edge loads a bubble and flush_cnt increments.
- Hold:
  - Stimulus: hold=1 for 3 cycles with changing id_*.
  - Response: ex_* unchanged throughout and no counter change. Capture resumes on the first edge after hold drops.
- Saturation:
  - Stimulus: CNT_W=4, apply 20 load-use stalls.
  - Response: stall_cnt=4'hF and stays there.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline encodings: ALU ops, control-bundle bit positions, x0
package riscv_pkg;

    localparam int CTRL_W = 7;

    // Control bundle order: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump}
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_JUMP     = 0;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [3:0]       id_alu_ctrl;
    logic [2:0]       id_funct3;
    logic [6:0]       id_ctrl;
    logic             ex_flush;
    logic             hold;

    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [3:0]       ex_alu_ctrl;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_ctrl;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_funct3, id_ctrl,
               ex_flush, hold,
        input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_funct3, ex_ctrl,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_funct3, id_ctrl,
               ex_flush, hold,
        output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_funct3, ex_ctrl,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard between EX load and ID consumer
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       lu_o
);
    logic rs1_hit;
    logic rs2_hit;

    // Only operands the instruction really reads count; lui/jal carry junk in rs fields.
    assign rs1_hit = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i & (id_rs2_i == ex_rd_i);

    assign lu_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != REG_X0) & id_valid_i
                & (rs1_hit | rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush bubble, hold and event counters
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
    logic [4:0]       ex_rs1_q,      ex_rs1_d;
    logic [4:0]       ex_rs2_q,      ex_rs2_d;
    logic [4:0]       ex_rd_q,       ex_rd_d;
    logic [3:0]       ex_alu_ctrl_q, ex_alu_ctrl_d;
    logic [2:0]       ex_funct3_q,   ex_funct3_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;
    logic             lu;

    load_use_detect u_lu (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rd_i       (ex_rd_q),
        .id_valid_i    (bus.id_valid),
        .id_uses_rs1_i (bus.id_uses_rs1),
        .id_uses_rs2_i (bus.id_uses_rs2),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .lu_o          (lu)
    );

    // A flushed ID instruction is wrong-path and hold already freezes upstream.
    assign bus.stall = lu & ~bus.ex_flush & ~bus.hold;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_alu_ctrl_d = ex_alu_ctrl_q;
        ex_funct3_d   = ex_funct3_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (bus.ex_flush || (!bus.hold && lu)) begin
            // Bubble clears register indices too so forwarding never matches it.
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_rs1_data_d = '0;
            ex_rs2_data_d = '0;
            ex_imm_d      = '0;
            ex_rs1_d      = '0;
            ex_rs2_d      = '0;
            ex_rd_d       = '0;
            ex_alu_ctrl_d = '0;
            ex_funct3_d   = '0;
            ex_ctrl_d     = '0;
            if (bus.ex_flush) begin
                if (ex_valid_q && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
            end else if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else if (!bus.hold) begin
            ex_valid_d    = bus.id_valid;
            ex_pc_d       = bus.id_pc;
            ex_rs1_data_d = bus.id_rs1_data;
            ex_rs2_data_d = bus.id_rs2_data;
            ex_imm_d      = bus.id_imm;
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
            ex_rd_d       = bus.id_rd;
            ex_alu_ctrl_d = bus.id_alu_ctrl;
            ex_funct3_d   = bus.id_funct3;
            ex_ctrl_d     = bus.id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_alu_ctrl_q <= '0;
            ex_funct3_q   <= '0;
            ex_ctrl_q     <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_alu_ctrl_q <= ex_alu_ctrl_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_alu_ctrl = ex_alu_ctrl_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 4;

    localparam logic [6:0] C_LW  = 7'b1101100;
    localparam logic [6:0] C_ADD = 7'b1000000;
    localparam logic [6:0] C_SW  = 7'b0010100;
    localparam logic [6:0] C_LUI = 7'b1000100;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic            u1, u2;
        logic [XLEN-1:0] d1, d2, imm;
        logic [3:0]      alu;
        logic [2:0]      f3;
        logic [6:0]      ctrl;
    } id_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      alu;
        logic [2:0]      f3;
        logic [6:0]      ctrl;
        logic [CW-1:0]   scnt, fcnt;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();
    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    ex_t sb[$];
    ex_t mdl;
    ex_t e, o;
    int  vec  = 0;
    int  miss = 0;

    function automatic id_t rid(bit v, logic [6:0] c, logic [4:0] r1, logic [4:0] r2,
                                logic [4:0] rd, bit u1, bit u2);
        id_t d;
        d.valid = v;    d.ctrl = c;
        d.rs1 = r1;     d.rs2 = r2;   d.rd = rd;
        d.u1 = u1;      d.u2 = u2;
        d.pc  = $urandom; d.d1 = $urandom; d.d2 = $urandom; d.imm = $urandom;
        d.alu = 4'($urandom_range(0, 10));
        d.f3  = 3'($urandom_range(0, 7));
        return d;
    endfunction

    function automatic bit model_lu(ex_t s, id_t d);
        return s.valid && s.ctrl[5] && (s.rd != 5'd0) && d.valid &&
               ((d.u1 && d.rs1 == s.rd) || (d.u2 && d.rs2 == s.rd));
    endfunction

    function automatic ex_t model_next(ex_t s, id_t d, bit fl, bit hd);
        ex_t n;
        n = s;
        if (fl || (!hd && model_lu(s, d))) begin
            n = '0;
            n.scnt = s.scnt;
            n.fcnt = s.fcnt;
            if (fl) begin
                if (s.valid && s.fcnt != 4'hF) n.fcnt = s.fcnt + 1'b1;
            end else if (s.scnt != 4'hF) begin
                n.scnt = s.scnt + 1'b1;
            end
        end else if (!hd) begin
            n.valid = d.valid; n.pc = d.pc; n.d1 = d.d1; n.d2 = d.d2; n.imm = d.imm;
            n.rs1 = d.rs1; n.rs2 = d.rs2; n.rd = d.rd;
            n.alu = d.alu; n.f3 = d.f3; n.ctrl = d.ctrl;
        end
        return n;
    endfunction

    function automatic ex_t observe();
        ex_t x;
        x.valid = bus.ex_valid;    x.pc = bus.ex_pc;
        x.d1 = bus.ex_rs1_data;    x.d2 = bus.ex_rs2_data;  x.imm = bus.ex_imm;
        x.rs1 = bus.ex_rs1;        x.rs2 = bus.ex_rs2;      x.rd = bus.ex_rd;
        x.alu = bus.ex_alu_ctrl;   x.f3 = bus.ex_funct3;    x.ctrl = bus.ex_ctrl;
        x.scnt = bus.stall_cnt;    x.fcnt = bus.flush_cnt;
        return x;
    endfunction

    task automatic drive(id_t d, bit fl, bit hd);
        bus.id_valid = d.valid;    bus.id_pc = d.pc;
        bus.id_rs1 = d.rs1;        bus.id_rs2 = d.rs2;      bus.id_rd = d.rd;
        bus.id_uses_rs1 = d.u1;    bus.id_uses_rs2 = d.u2;
        bus.id_rs1_data = d.d1;    bus.id_rs2_data = d.d2;  bus.id_imm = d.imm;
        bus.id_alu_ctrl = d.alu;   bus.id_funct3 = d.f3;    bus.id_ctrl = d.ctrl;
        bus.ex_flush = fl;         bus.hold = hd;
    endtask

    task automatic apply(id_t d, bit fl, bit hd);
        drive(d, fl, hd);
        mdl = model_next(mdl, d, fl, hd);
        sb.push_back(mdl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b0);
        #2;
        o = observe(); vec++;
        if (o !== '0) begin $display("FAIL reset_init obs=%h exp=0", o); miss++; end
        tick();
        rst = 1'b0;
        mdl = '0;
        apply(rid(1, 7'h7F, 5'd1, 5'd2, 5'd9, 1, 1), 0, 0);
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL reset_load obs=%h exp=%h", o, e); miss++; end
        rst = 1'b1;
        #1;
        o = observe(); vec++;
        if (o !== '0) begin $display("FAIL reset_async obs=%h exp=0", o); miss++; end
        mdl = '0;
        sb.delete();
        drive('0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        id_t add;
        apply(rid(1, C_LW, 5'd2, 5'd0, 5'd5, 1, 0), 0, 0);
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL lu_load obs=%h exp=%h", o, e); miss++; end
        add = rid(1, C_ADD, 5'd5, 5'd7, 5'd6, 1, 1);
        apply(add, 0, 0);
        #1; vec++;
        if (bus.stall !== 1'b1) begin $display("FAIL lu_stall obs=%b exp=1", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e || o.valid !== 1'b0 || o.rd !== 5'd0)
            begin $display("FAIL lu_bubble obs=%h exp=%h", o, e); miss++; end
        apply(add, 0, 0);
        #1; vec++;
        if (bus.stall !== 1'b0) begin $display("FAIL lu_release obs=%b exp=0", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e || o.pc !== add.pc) begin $display("FAIL lu_capture obs=%h exp=%h", o, e); miss++; end
    endtask

    task automatic test_no_false_stall();
        apply(rid(1, C_LW, 5'd3, 5'd0, 5'd0, 1, 0), 0, 0);
        tick();
        e = sb.pop_front();
        apply(rid(1, C_ADD, 5'd0, 5'd0, 5'd8, 1, 1), 0, 0);
        #1; vec++;
        if (bus.stall !== 1'b0) begin $display("FAIL nfs_x0 obs=%b exp=0", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL nfs_x0_cap obs=%h exp=%h", o, e); miss++; end
        apply(rid(1, C_LW, 5'd3, 5'd0, 5'd5, 1, 0), 0, 0);
        tick();
        e = sb.pop_front();
        apply(rid(1, C_LUI, 5'd5, 5'd5, 5'd4, 0, 0), 0, 0);
        #1; vec++;
        if (bus.stall !== 1'b0) begin $display("FAIL nfs_lui obs=%b exp=0", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL nfs_lui_cap obs=%h exp=%h", o, e); miss++; end
    endtask

    task automatic test_flush();
        apply(rid(1, C_LW, 5'd1, 5'd0, 5'd5, 1, 0), 0, 0);
        tick();
        e = sb.pop_front();
        apply(rid(1, C_SW, 5'd2, 5'd5, 5'd0, 1, 1), 1, 1);
        #1; vec++;
        if (bus.stall !== 1'b0) begin $display("FAIL flush_stall obs=%b exp=0", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e || o.valid !== 1'b0) begin $display("FAIL flush_bubble obs=%h exp=%h", o, e); miss++; end
        apply(rid(1, C_ADD, 5'd1, 5'd2, 5'd3, 1, 1), 1, 0);
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL flush_of_bubble obs=%h exp=%h", o, e); miss++; end
    endtask

    task automatic test_hold();
        apply(rid(1, C_LW, 5'd1, 5'd0, 5'd5, 1, 0), 0, 0);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            apply(rid(1, C_ADD, 5'd5, 5'($urandom_range(0, 31)), 5'd6, 1, 1), 0, 1);
            #1; vec++;
            if (bus.stall !== 1'b0) begin $display("FAIL hold_stall[%0d] obs=%b exp=0", i, bus.stall); miss++; end
            tick();
            e = sb.pop_front(); o = observe(); vec++;
            if (o !== e) begin $display("FAIL hold_keep[%0d] obs=%h exp=%h", i, o, e); miss++; end
        end
        apply(rid(1, C_ADD, 5'd5, 5'd9, 5'd6, 1, 1), 0, 0);
        #1; vec++;
        if (bus.stall !== 1'b1) begin $display("FAIL hold_drop_stall obs=%b exp=1", bus.stall); miss++; end
        tick();
        e = sb.pop_front(); o = observe(); vec++;
        if (o !== e) begin $display("FAIL hold_drop obs=%h exp=%h", o, e); miss++; end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            apply(rid(1, C_LW, 5'd1, 5'd0, 5'd5, 1, 0), 0, 0);
            tick();
            e = sb.pop_front();
            apply(rid(1, C_SW, 5'd2, 5'd5, 5'd0, 1, 1), 0, 0);
            #1; vec++;
            if (bus.stall !== 1'b1) begin $display("FAIL sat_stall[%0d] obs=%b exp=1", i, bus.stall); miss++; end
            tick();
            e = sb.pop_front(); o = observe(); vec++;
            if (o !== e) begin $display("FAIL sat_cnt[%0d] obs=%h exp=%h", i, o, e); miss++; end
        end
        vec++;
        if (bus.stall_cnt !== 4'hF) begin $display("FAIL sat_final obs=%h exp=f", bus.stall_cnt); miss++; end
    endtask

    task automatic test_back_to_back();
        id_t d;
        bit  fl, hd, exp_stall;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                d = rid(0, 7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            else
                d = rid(1, 7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            fl = ($urandom_range(0, 7) == 0);
            hd = ($urandom_range(0, 5) == 0);
            exp_stall = model_lu(mdl, d) && !fl && !hd;
            apply(d, fl, hd);
            #1; vec++;
            if (bus.stall !== exp_stall) begin $display("FAIL b2b_stall[%0d] obs=%b exp=%b", i, bus.stall, exp_stall); miss++; end
            tick();
            e = sb.pop_front(); o = observe(); vec++;
            if (o !== e) begin $display("FAIL b2b[%0d] obs=%h exp=%h", i, o, e); miss++; end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_hold();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
